// File: rtl/rwl_pulse_driver_pkg.sv
// Shared constants and helpers for the RWL pulse driver.
// State codes are fixed for compatibility with older tools.
package rwl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int rows(input int aw);
    return 1 << aw;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rwl_pulse_driver_if.sv
// Read-port request bus and wordline strips.
// Master is the read controller, slave is the driver.
interface rwl_pulse_driver_if
  import rwl_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_PORTS  = 2,
  localparam int ROWS      = rows(ADDR_WIDTH)
);

  logic [NUM_PORTS-1:0]            REQ;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR;
  logic [NUM_PORTS-1:0]            BUSY;
  logic [NUM_PORTS-1:0]            DONE;
  logic [NUM_PORTS*ROWS-1:0]       RWL;

  modport master (
    output REQ, ADDR,
    input  BUSY, DONE, RWL
  );

  modport slave (
    input  REQ, ADDR,
    output BUSY, DONE, RWL
  );

endinterface

// File: rtl/rwl_pulse_driver_port_fsm.sv
// One read port: request capture, pulse/gap sequencing,
// registered one-hot wordline strip with DONE/BUSY.
module rwl_port_fsm
  import rwl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  localparam int ROWS        = rows(ADDR_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ROWS-1:0]       o_rwl
);

  localparam int CW =
    $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);

  if ((PULSE_CYCLES < 1) || (GAP_CYCLES < 1)) begin : g_bad
    $error("rwl_port_fsm: cycle counts must be >= 1");
  end

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ROWS-1:0]       r_rwl;
  logic                  r_busy;
  logic                  r_done;

  function automatic logic [ROWS-1:0] dec(
    input logic [ADDR_WIDTH-1:0] a
  );
    dec    = '0;
    dec[a] = 1'b1;
  endfunction

  // Every DRIVE exit goes through GAP, so the strip
  // never moves directly from one row to another.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rwl   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_state <= ST_DRIVE;
            r_addr  <= i_addr;
            r_cnt   <= CW'(PULSE_CYCLES - 1);
            r_rwl   <= dec(i_addr);
            r_busy  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_rwl <= dec(r_addr);
          end else begin
            r_state <= ST_GAP;
            r_cnt   <= CW'(GAP_CYCLES - 1);
            r_rwl   <= '0;
            r_done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_rwl   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_rwl  = r_rwl;

endmodule

// File: rtl/rwl_pulse_driver.sv
// Multi-port registered read-wordline driver:
// one independent pulse FSM per read port.
module rwl_pulse_driver
  import rwl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int NUM_PORTS    = 2,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  localparam int ROWS        = rows(ADDR_WIDTH)
) (
  input  logic          CLK,
  input  logic          RST,
  rwl_pulse_driver_if.slave bus
);

  logic [NUM_PORTS-1:0]      w_busy;
  logic [NUM_PORTS-1:0]      w_done;
  logic [NUM_PORTS*ROWS-1:0] w_rwl;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rwl_port_fsm #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .PULSE_CYCLES (PULSE_CYCLES),
      .GAP_CYCLES   (GAP_CYCLES)
    ) u_fsm (
      .CLK    (CLK),
      .RST    (RST),
      .i_req  (bus.REQ[p]),
      .i_addr (bus.ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .o_busy (w_busy[p]),
      .o_done (w_done[p]),
      .o_rwl  (w_rwl[p*ROWS +: ROWS])
    );
  end

  assign bus.BUSY = w_busy;
  assign bus.DONE = w_done;
  assign bus.RWL  = w_rwl;

endmodule

// File: tb/tb_rwl_pulse_driver.sv
// Directed bench: default driver plus a PULSE=1/GAP=3
// variant, with a per-cycle one-hot strip scoreboard.
module tb_rwl_pulse_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sb_on = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rwl_pulse_driver_if #(.ADDR_WIDTH(3), .NUM_PORTS(2)) ifa ();
  rwl_pulse_driver_if #(.ADDR_WIDTH(3), .NUM_PORTS(2)) ifb ();

  rwl_pulse_driver #(
    .ADDR_WIDTH(3), .NUM_PORTS(2),
    .PULSE_CYCLES(2), .GAP_CYCLES(1)
  ) u_a (
    .CLK (clk),
    .RST (rst),
    .bus (ifa.slave)
  );

  rwl_pulse_driver #(
    .ADDR_WIDTH(3), .NUM_PORTS(2),
    .PULSE_CYCLES(1), .GAP_CYCLES(3)
  ) u_b (
    .CLK (clk),
    .RST (rst),
    .bus (ifb.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(
    input string       tag,
    input logic [15:0] rwl,
    input logic [1:0]  busy,
    input logic [1:0]  done
  );
    chk({tag, ".rwl"},  32'(ifa.RWL),  32'(rwl));
    chk({tag, ".busy"}, 32'(ifa.BUSY), 32'(busy));
    chk({tag, ".done"}, 32'(ifa.DONE), 32'(done));
  endtask

  // Issue a one-cycle REQ on the ports in m and walk the
  // full pulse (2 cycles), gap (1 cycle) and return to idle.
  task automatic pulse_a(
    input string       tag,
    input logic [1:0]  m,
    input logic [15:0] rwl
  );
    ifa.REQ = m;
    tick();
    chk_a({tag, ".e0"}, rwl, m, 2'b00);
    ifa.REQ = 2'b00;
    tick();
    chk_a({tag, ".e1"}, rwl, m, 2'b00);
    tick();
    chk_a({tag, ".e2"}, 16'h0, m, m);
    tick();
    chk_a({tag, ".e3"}, 16'h0, 2'b00, 2'b00);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      chk("oh.a0", 32'($onehot0(ifa.RWL[7:0])),  32'd1);
      chk("oh.a1", 32'($onehot0(ifa.RWL[15:8])), 32'd1);
      chk("oh.b0", 32'($onehot0(ifb.RWL[7:0])),  32'd1);
      chk("oh.b1", 32'($onehot0(ifb.RWL[15:8])), 32'd1);
    end
  end

  initial begin
    ifa.REQ  = 2'b11;
    ifa.ADDR = '0;
    ifb.REQ  = 2'b00;
    ifb.ADDR = '0;
    rst      = 1'b1;

    tick();
    sb_on = 1'b1;
    chk_a("rst1", 16'h0, 2'b00, 2'b00);
    tick();
    chk_a("rst2", 16'h0, 2'b00, 2'b00);
    chk("rst.b.busy", 32'(ifb.BUSY), 32'd0);

    // first REQ after reset release, port0=2 port1=3
    rst      = 1'b0;
    ifa.ADDR = {3'd3, 3'd2};
    pulse_a("post_rst", 2'b11, 16'h0804);

    ifa.ADDR = {3'd0, 3'd0};
    pulse_a("p0_row0", 2'b01, 16'h0001);

    ifa.ADDR = {3'd1, 3'd6};
    pulse_a("both", 2'b11, 16'h0240);

    // held REQ, address change mid-pulse
    ifa.ADDR = {3'd0, 3'd4};
    ifa.REQ  = 2'b01;
    tick();
    chk_a("hold.e0", 16'h0010, 2'b01, 2'b00);
    ifa.ADDR = {3'd0, 3'd5};
    tick();
    chk_a("hold.e1", 16'h0010, 2'b01, 2'b00);
    tick();
    chk_a("hold.e2", 16'h0000, 2'b01, 2'b01);
    tick();
    chk_a("hold.e3", 16'h0000, 2'b00, 2'b00);
    tick();
    chk_a("hold.e4", 16'h0020, 2'b01, 2'b00);
    ifa.REQ = 2'b00;
    tick();
    chk_a("hold.e5", 16'h0020, 2'b01, 2'b00);
    tick();
    chk_a("hold.e6", 16'h0000, 2'b01, 2'b01);
    tick();
    chk_a("hold.e7", 16'h0000, 2'b00, 2'b00);

    // reset during the second DRIVE cycle of port1
    ifa.ADDR = {3'd7, 3'd0};
    ifa.REQ  = 2'b10;
    tick();
    chk_a("mrst.e0", 16'h8000, 2'b10, 2'b00);
    ifa.REQ = 2'b00;
    rst     = 1'b1;
    tick();
    chk_a("mrst.e1", 16'h0000, 2'b00, 2'b00);
    rst = 1'b0;
    tick();
    chk_a("mrst.e2", 16'h0000, 2'b00, 2'b00);
    tick();
    chk_a("mrst.e3", 16'h0000, 2'b00, 2'b00);

    // PULSE=1, GAP=3 variant, top row of port0
    ifb.ADDR = {3'd0, 3'd7};
    ifb.REQ  = 2'b01;
    tick();
    chk("b.e0.rwl",  32'(ifb.RWL),  32'h0080);
    chk("b.e0.busy", 32'(ifb.BUSY), 32'd1);
    chk("b.e0.done", 32'(ifb.DONE), 32'd0);
    ifb.REQ = 2'b00;
    tick();
    chk("b.e1.rwl",  32'(ifb.RWL),  32'h0000);
    chk("b.e1.busy", 32'(ifb.BUSY), 32'd1);
    chk("b.e1.done", 32'(ifb.DONE), 32'd1);
    tick();
    chk("b.e2.busy", 32'(ifb.BUSY), 32'd1);
    chk("b.e2.done", 32'(ifb.DONE), 32'd0);
    tick();
    chk("b.e3.busy", 32'(ifb.BUSY), 32'd1);
    chk("b.e3.rwl",  32'(ifb.RWL),  32'h0000);
    tick();
    chk("b.e4.busy", 32'(ifb.BUSY), 32'd0);
    chk("b.e4.done", 32'(ifb.DONE), 32'd0);

    tick();
    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
